// File: rtl/layer_sequencer.sv
// Game-level display sequencer: TITLE -> PLAY -> WIN/LOSE -> TITLE, driving mixer
// layer enables that only change on frame boundaries so no frame shows a partial switch.
module layer_sequencer #(
    parameter int unsigned SPLASH_FRAMES = 120,
    parameter int unsigned BLINK_FRAMES  = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic       start_btn,
    input  logic       game_won,
    input  logic       game_lost,
    output logic       splash_on,
    output logic [1:0] splash_sel,
    output logic       icon_on,
    output logic       game_run
);

    localparam int unsigned FW = $clog2(SPLASH_FRAMES + 1);
    localparam int unsigned BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(SPLASH_FRAMES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {S_TITLE, S_PLAY, S_WIN, S_LOSE} state_e;

    state_e          state_q, state_d;
    logic            vsync_q, start_q;
    logic            frame_tick, start_rise;
    logic [FW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_q, blink_d;
    logic            splash_on_q, splash_on_d;
    logic [1:0]      splash_sel_q, splash_sel_d;
    logic            icon_on_q, icon_on_d;
    logic            game_run_q, game_run_d;

    assign frame_tick = vsync_q & ~vsync;
    assign start_rise = start_btn & ~start_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_TITLE;
            vsync_q      <= 1'b0;
            start_q      <= 1'b0;
            frame_cnt_q  <= '0;
            blink_cnt_q  <= '0;
            blink_q      <= 1'b1;
            splash_on_q  <= 1'b1;
            splash_sel_q <= 2'd0;
            icon_on_q    <= 1'b0;
            game_run_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            vsync_q      <= vsync;
            start_q      <= start_btn;
            frame_cnt_q  <= frame_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_q      <= blink_d;
            splash_on_q  <= splash_on_d;
            splash_sel_q <= splash_sel_d;
            icon_on_q    <= icon_on_d;
            game_run_q   <= game_run_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        blink_d      = blink_q;
        splash_on_d  = splash_on_q;
        splash_sel_d = splash_sel_q;
        icon_on_d    = icon_on_q;

        unique case (state_q)
            S_TITLE: if (start_rise) state_d = S_PLAY;
            S_PLAY: begin
                if (game_won)       state_d = S_WIN;
                else if (game_lost) state_d = S_LOSE;
            end
            S_WIN, S_LOSE: if (frame_tick && frame_cnt_q == FRAME_LAST) state_d = S_TITLE;
            default: state_d = S_TITLE;
        endcase

        // Counters restart on every state entry; blink phase starts "on".
        if (state_d != state_q) begin
            frame_cnt_d = '0;
            blink_cnt_d = '0;
            blink_d     = 1'b1;
        end else if (frame_tick && (state_q == S_WIN || state_q == S_LOSE)) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        // Layer controls follow the pre-edge state, so a transition shows one frame late.
        if (frame_tick) begin
            unique case (state_q)
                S_TITLE: begin
                    splash_on_d  = 1'b1;
                    splash_sel_d = 2'd0;
                    icon_on_d    = 1'b0;
                end
                S_PLAY: begin
                    splash_on_d = 1'b0;
                    icon_on_d   = 1'b1;
                end
                S_WIN: begin
                    splash_on_d  = 1'b1;
                    splash_sel_d = 2'd1;
                    icon_on_d    = blink_q;
                end
                S_LOSE: begin
                    splash_on_d  = 1'b1;
                    splash_sel_d = 2'd2;
                    icon_on_d    = blink_q;
                end
                default: ;
            endcase
        end

        game_run_d = (state_d == S_PLAY);
    end

    assign splash_on  = splash_on_q;
    assign splash_sel = splash_sel_q;
    assign icon_on    = icon_on_q;
    assign game_run   = game_run_q;

endmodule
